// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: shifts two WIDTH-bit operands LSB-first through one
// Full_Adder cell, registering the carry between bits, with start/busy/done.

module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry_r;
  logic [CNT_W-1:0] cnt;
  logic             a_msb, b_msb;
  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  Full_Adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry_r),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // The final sum bit is folded in on the same edge that publishes the result.
  assign res_next = {fa_sum, res_sr[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry_r  <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      sum_out  <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            carry_r <= cin;
            cnt     <= '0;
            a_msb   <= a_in[WIDTH-1];
            b_msb   <= b_in[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_next;
          carry_r <= fa_carry;
          if (last_bit) begin
            sum_out  <= res_next;
            cout     <= fa_carry;
            overflow <= (a_msb == b_msb) && (fa_sum != a_msb);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases from the feature
// list plus random operands checked against an arithmetic reference model.

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             cin = 1'b0;
  logic             busy, done, cout, overflow;
  logic [WIDTH-1:0] sum_out;

  int n_chk = 0;
  int n_err = 0;

  logic [WIDTH-1:0] hold_sum = '0;
  logic             hold_cout = 1'b0;
  logic             hold_ovf = 1'b0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic logic [WIDTH:0] ref_total(input logic [WIDTH-1:0] a, b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return t[WIDTH:0];
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] a, b, input logic c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (s > (2 ** (WIDTH - 1)) - 1) || (s < -(2 ** (WIDTH - 1)));
  endfunction

  // One operation: accept, watch busy/holding through SHIFT, check latency and
  // result on done, then confirm the single-cycle pulse. A start pulse with
  // junk operands is injected after SHIFT edge 'inj' when inj > 0.
  task automatic run_op(input logic [WIDTH-1:0] a, b, input logic c, input int inj);
    logic [WIDTH:0] tot;
    int             lat;
    tot = ref_total(a, b, c);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 3 * WIDTH; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1 || sum_out !== hold_sum || cout !== hold_cout || overflow !== hold_ovf)
        chk("busy_hold_in_shift", {busy, cout, overflow, 21'd0, sum_out},
            {1'b1, hold_cout, hold_ovf, 21'd0, hold_sum});
      if (k == inj) begin
        start = 1'b1; a_in = 8'h7F; b_in = 8'h7F;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(WIDTH));
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("sum", 32'(sum_out), 32'(tot[WIDTH-1:0]));
    chk("cout", 32'(cout), 32'(tot[WIDTH]));
    chk("overflow", 32'(overflow), 32'(ref_ovf(a, b, c)));
    hold_sum = tot[WIDTH-1:0]; hold_cout = tot[WIDTH]; hold_ovf = ref_ovf(a, b, c);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic idle_hold(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done || busy || sum_out !== hold_sum || cout !== hold_cout) bad++;
    end
    chk("idle_hold", 32'(bad), 32'd0);
  endtask

  initial begin
    int last_done, pulses, gap_bad, sum_bad;

    #12;
    chk("rst_state", {busy, done, cout, overflow, 20'd0, sum_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(8'h5A, 8'h33, 1'b0, 0);
    chk("dir_5a33_sum", 32'(sum_out), 32'h8D);
    chk("dir_5a33_ovf", 32'(overflow), 32'd1);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    chk("dir_ff01", {cout, sum_out}, {1'b1, 8'h00});
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    chk("dir_ffff1", {overflow, cout, sum_out}, {1'b0, 1'b1, 8'hFF});
    run_op(8'h80, 8'h80, 1'b0, 0);
    chk("dir_8080", {overflow, cout, sum_out}, {1'b1, 1'b1, 8'h00});

    // start during SHIFT is ignored: one pulse, result of first operands only
    run_op(8'h01, 8'h02, 1'b0, 3);
    chk("ignore_mid_start", 32'(sum_out), 32'h03);
    idle_hold(12);

    // start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge clk);
    a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
    last_done = -1; pulses = 0; gap_bad = 0; sum_bad = 0;
    for (int t = 0; t < 5 * (WIDTH + 2) + 2; t++) begin
      @(posedge clk); #1;
      if (done) begin
        if (last_done >= 0 && t - last_done != WIDTH + 2) gap_bad++;
        if (sum_out !== 8'h30) sum_bad++;
        last_done = t;
        pulses++;
      end
    end
    @(negedge clk); start = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd5);
    chk("b2b_gap", 32'(gap_bad), 32'd0);
    chk("b2b_sum", 32'(sum_bad), 32'd0);
    for (int i = 0; i < 2 * WIDTH && busy; i++) @(posedge clk);
    #1;
    hold_sum = 8'h30; hold_cout = 1'b0; hold_ovf = 1'b0;
    chk("b2b_drained", 32'(busy), 32'd0);

    // reset in the middle of SHIFT aborts with no done
    @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("abort_outputs", {busy, done, cout, overflow, 20'd0, sum_out}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    hold_sum = '0; hold_cout = 1'b0; hold_ovf = 1'b0;
    run_op(8'h0F, 8'h01, 1'b0, 0);
    chk("after_reset", {cout, sum_out}, {1'b0, 8'h10});

    // random operands against the reference model
    for (int r = 0; r < 40; r++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0);
      if (($urandom % 4) == 0) idle_hold(int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
